sw_job_dispatcher: RTL and testbench
====================================

# sw_job_dispatcher

Parametrised multi-core front end for the Smith-Waterman accelerator. Accepts alignment jobs (ref/read sequences plus lengths) on one valid/ready stream, dispatches each to one of NUM_CORES `SW_core` instances attached on flattened core-side ports, and returns score/row/column results with a job tag. Results return in issue order through a reorder buffer, or in completion order when that buffer is compiled out. Sits between the host/DMA job source and the SW core array; single-core flows use NUM_CORES=1.

## Interface
Parameters:
- NUM_CORES, 4, number of attached SW cores; power of two, 1..16
- REF_MAX, 128, max reference length in bases (2 bits/base)
- READ_MAX, 128, max read length in bases
- SCORE_W, 16, signed alignment score width
- TAG_W, 4, job tag width; TAG_W >= log2(NUM_CORES)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- s_valid  in  1  job valid
- s_ready  out  1  job accepted when s_valid & s_ready
- s_ref  in  2*REF_MAX  reference sequence, MSB-aligned
- s_read  in  2*READ_MAX  read sequence, MSB-aligned
- s_ref_len  in  log2(REF_MAX)+1  reference length, 1-based
- s_read_len  in  log2(READ_MAX)+1  read length, 1-based
- s_tag  out  TAG_W  tag given to the job accepted this cycle
- c_ready  in  NUM_CORES  per-core o_ready
- c_valid  out  NUM_CORES  per-core i_valid, one-hot or zero
- c_ref, c_read, c_ref_len, c_read_len  out  as s_*  shared registered job bus
- c_res_valid  in  NUM_CORES  per-core o_valid
- c_res_ready  out  NUM_CORES  per-core i_ready
- c_score  in  NUM_CORES*SCORE_W  per-core scores, core i at slice i
- c_row  in  NUM_CORES*log2(READ_MAX)  per-core end rows
- c_col  in  NUM_CORES*log2(REF_MAX)  per-core end columns
- m_valid  out  1  result valid
- m_ready  in  1  result consumed when m_valid & m_ready
- m_score, m_row, m_col  out  SCORE_W / log2(READ_MAX) / log2(REF_MAX)  result
- m_tag  out  TAG_W  tag of the job producing this result
- m_core  out  log2(NUM_CORES) (min 1)  core that produced the result
- busy_cnt  out  log2(NUM_CORES)+1  cores currently holding a job

## Operation
- Per-core busy bit: set on dispatch, cleared when that core's result handshake (c_res_valid & c_res_ready) completes.
- Core i is free when busy[i]=0 and c_ready[i]=1. s_ready = any core free (and, with reorder, outstanding < NUM_CORES).
- Selection: round-robin from pointer rr; winner is first free core at or after rr; rr <= winner+1 mod NUM_CORES on accept.
- On accept: job registered onto c_* bus, c_valid[winner]=1 for exactly one cycle, core's tag register <= next_tag, next_tag <= next_tag+1 (wraps mod 2^TAG_W).
- c_* data buses hold last dispatched job; compared only when c_valid set.
- Reorder (SW_REORDER_EN): ROB of NUM_CORES entries, slot = tag mod NUM_CORES. c_res_ready[i]=busy[i]; result written to slot of core i's tag on handshake. Head pointer issues slot to output register when valid and output register empty or draining; head advances.
- Completion order (no macro): round-robin arbiter over c_res_valid & busy; c_res_ready asserted only for winner, only when output register empty or draining.
- Output register: m_* stable while m_valid=1 and m_ready=0.
- busy_cnt = popcount(busy).

## Timing
- Reset (rst=0, asynchronous): s_ready=0 until first clock after release; c_valid=0, c_res_ready=0, m_valid=0, m_score/m_row/m_col/m_tag/m_core=0, busy_cnt=0, rr=0, next_tag=0, ROB empty. Reset mid-job drops all outstanding jobs; core results arriving after are not accepted until cores re-issue o_ready.
- Accept at edge t -> c_valid high during cycle t+1 only; busy set at edge t.
- Same core cannot be dispatched in cycle t+1 (busy already set).
- Result handshake at edge t -> m_valid at t+1 (output register empty) -> earliest re-dispatch to that core at t+1.
- Simultaneous results from several cores: all captured same cycle in reorder mode; one per cycle in completion mode.
- Simultaneous dispatch and result on same core impossible (busy); dispatch and result on different cores proceed independently.
- Throughput: one job accepted per cycle while free cores exist; one result per cycle at m_*.

## Configuration
- SW_REORDER_EN defined: ROB present, results leave in tag order (0,1,2,... wrapping), outstanding jobs capped at NUM_CORES.
- SW_REORDER_EN undefined: no ROB, results leave in completion order with round-robin tie-break; m_tag identifies the job; lower area.

## Test plan
- Reset then one job (ref/read 128 bases, lens 128/128) on NUM_CORES=4 -> c_valid=4'b0001 one cycle after accept, s_tag=0; core model returns score 57 row 101 col 99 -> m_valid next cycle with m_tag=0, m_core=0, same values.
- Five back-to-back jobs, all cores ready -> c_valid 0001,0010,0100,1000 on consecutive cycles, s_ready=0 for fifth until a core completes, busy_cnt=4.
- SW_REORDER_EN: cores finish in order 3,1,0,2 -> m_tag sequence 0,1,2,3; without macro -> m_tag 3,1,0,2.
- m_ready held 0 for 10 cycles with result pending -> m_* unchanged, c_res_ready low for further results (no macro) / ROB fills but no loss (macro); release -> all results delivered once.
- 20 jobs with TAG_W=4 -> tags wrap 15->0, no duplicate or missing result tags.
- Assert rst low with 3 jobs outstanding -> all outputs reach reset values asynchronously, busy_cnt=0, next job after release gets tag 0 on core 0.

Source files
------------

// File: rtl/sw_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module : sw_job_dispatcher
// Round-robin job dispatcher and result collector for an array of SW cores.
// Build option: define SW_REORDER_EN for in-order (tag order) results via ROB.
// Rev    : 1.0
// ============================================================================
module sw_job_dispatcher #(
  parameter int NUM_CORES = 4,
  parameter int REF_MAX   = 128,
  parameter int READ_MAX  = 128,
  parameter int SCORE_W   = 16,
  parameter int TAG_W     = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  s_valid,
  output logic                                                  s_ready,
  input  logic [2*REF_MAX-1:0]                                  s_ref,
  input  logic [2*READ_MAX-1:0]                                 s_read,
  input  logic [$clog2(REF_MAX):0]                              s_ref_len,
  input  logic [$clog2(READ_MAX):0]                             s_read_len,
  output logic [TAG_W-1:0]                                      s_tag,
  input  logic [NUM_CORES-1:0]                                  c_ready,
  output logic [NUM_CORES-1:0]                                  c_valid,
  output logic [2*REF_MAX-1:0]                                  c_ref,
  output logic [2*READ_MAX-1:0]                                 c_read,
  output logic [$clog2(REF_MAX):0]                              c_ref_len,
  output logic [$clog2(READ_MAX):0]                             c_read_len,
  input  logic [NUM_CORES-1:0]                                  c_res_valid,
  output logic [NUM_CORES-1:0]                                  c_res_ready,
  input  logic [NUM_CORES*SCORE_W-1:0]                          c_score,
  input  logic [NUM_CORES*$clog2(READ_MAX)-1:0]                 c_row,
  input  logic [NUM_CORES*$clog2(REF_MAX)-1:0]                  c_col,
  output logic                                                  m_valid,
  input  logic                                                  m_ready,
  output logic [SCORE_W-1:0]                                    m_score,
  output logic [$clog2(READ_MAX)-1:0]                           m_row,
  output logic [$clog2(REF_MAX)-1:0]                            m_col,
  output logic [TAG_W-1:0]                                      m_tag,
  output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0]  m_core,
  output logic [$clog2(NUM_CORES):0]                            busy_cnt
);

  localparam int CW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int ROWW = $clog2(READ_MAX);
  localparam int COLW = $clog2(REF_MAX);
  localparam int BCW  = $clog2(NUM_CORES) + 1;

  function automatic logic [CW-1:0] f_wrap(input int v);
    return CW'(v % NUM_CORES);
  endfunction

  logic                      r_en;
  logic [NUM_CORES-1:0]      r_busy;
  logic [CW-1:0]             r_rr;
  logic [TAG_W-1:0]          r_next_tag;
  logic [TAG_W-1:0]          r_core_tag [NUM_CORES];
  logic [NUM_CORES-1:0]      r_c_valid;
  logic [2*REF_MAX-1:0]      r_c_ref;
  logic [2*READ_MAX-1:0]     r_c_read;
  logic [$clog2(REF_MAX):0]  r_c_ref_len;
  logic [$clog2(READ_MAX):0] r_c_read_len;
  logic                      r_m_valid;
  logic [SCORE_W-1:0]        r_m_score;
  logic [ROWW-1:0]           r_m_row;
  logic [COLW-1:0]           r_m_col;
  logic [TAG_W-1:0]          r_m_tag;
  logic [CW-1:0]             r_m_core;

  logic [NUM_CORES-1:0]      w_free;
  logic [NUM_CORES-1:0]      w_win_oh;
  logic [NUM_CORES-1:0]      w_res_ready;
  logic [NUM_CORES-1:0]      w_res_hs;
  logic [CW-1:0]             w_win;
  logic                      w_any_free;
  logic                      w_s_ready;
  logic                      w_accept;
  logic                      w_out_load;
  logic                      w_issue;
  logic [SCORE_W-1:0]        w_iss_score;
  logic [ROWW-1:0]           w_iss_row;
  logic [COLW-1:0]           w_iss_col;
  logic [TAG_W-1:0]          w_iss_tag;
  logic [CW-1:0]             w_iss_core;
  logic [BCW-1:0]            w_busy_cnt;

  assign w_free   = ~r_busy & c_ready;
  assign w_win_oh = NUM_CORES'(1) << w_win;
  assign w_accept = s_valid & w_s_ready;
  assign w_res_hs = c_res_valid & w_res_ready;

  // Descending scan so the lowest offset from r_rr is the last (winning) write.
  always_comb begin
    w_any_free = 1'b0;
    w_win      = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (w_free[f_wrap(int'(r_rr) + k)]) begin
        w_any_free = 1'b1;
        w_win      = f_wrap(int'(r_rr) + k);
      end
    end
  end

  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_busy_cnt = w_busy_cnt + BCW'(r_busy[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en         <= 1'b0;
      r_busy       <= '0;
      r_rr         <= '0;
      r_next_tag   <= '0;
      r_c_valid    <= '0;
      r_c_ref      <= '0;
      r_c_read     <= '0;
      r_c_ref_len  <= '0;
      r_c_read_len <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        r_core_tag[i] <= '0;
      end
    end else begin
      r_en      <= 1'b1;
      r_c_valid <= '0;
      if (w_accept) begin
        r_c_valid           <= w_win_oh;
        r_c_ref             <= s_ref;
        r_c_read            <= s_read;
        r_c_ref_len         <= s_ref_len;
        r_c_read_len        <= s_read_len;
        r_core_tag[w_win]   <= r_next_tag;
        r_next_tag          <= r_next_tag + TAG_W'(1);
        r_rr                <= f_wrap(int'(w_win) + 1);
      end
      r_busy <= (r_busy & ~w_res_hs) | (w_accept ? w_win_oh : '0);
    end
  end

  assign w_out_load = ~r_m_valid | m_ready;

`ifdef SW_REORDER_EN
  logic [NUM_CORES-1:0] r_rob_v;
  logic [SCORE_W-1:0]   r_rob_score [NUM_CORES];
  logic [ROWW-1:0]      r_rob_row   [NUM_CORES];
  logic [COLW-1:0]      r_rob_col   [NUM_CORES];
  logic [CW-1:0]        r_rob_core  [NUM_CORES];
  logic [TAG_W-1:0]     r_head_tag;
  logic [BCW-1:0]       r_outstanding;
  logic [CW-1:0]        w_head;
  logic                 w_byp_hit;
  logic [SCORE_W-1:0]   w_byp_score;
  logic [ROWW-1:0]      w_byp_row;
  logic [COLW-1:0]      w_byp_col;
  logic [CW-1:0]        w_byp_core;

  assign w_s_ready   = r_en & w_any_free & (r_outstanding < BCW'(NUM_CORES));
  assign w_res_ready = r_busy;
  assign w_head      = f_wrap(int'(r_head_tag));

  // A result arriving for the head slot goes straight to the output register.
  always_comb begin
    w_byp_hit   = 1'b0;
    w_byp_score = '0;
    w_byp_row   = '0;
    w_byp_col   = '0;
    w_byp_core  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_res_hs[i] && (f_wrap(int'(r_core_tag[i])) == w_head)) begin
        w_byp_hit   = 1'b1;
        w_byp_score = c_score[i*SCORE_W +: SCORE_W];
        w_byp_row   = c_row[i*ROWW +: ROWW];
        w_byp_col   = c_col[i*COLW +: COLW];
        w_byp_core  = CW'(i);
      end
    end
  end

  assign w_issue     = w_out_load & (r_rob_v[w_head] | w_byp_hit);
  assign w_iss_score = r_rob_v[w_head] ? r_rob_score[w_head] : w_byp_score;
  assign w_iss_row   = r_rob_v[w_head] ? r_rob_row[w_head]   : w_byp_row;
  assign w_iss_col   = r_rob_v[w_head] ? r_rob_col[w_head]   : w_byp_col;
  assign w_iss_core  = r_rob_v[w_head] ? r_rob_core[w_head]  : w_byp_core;
  assign w_iss_tag   = r_head_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rob_v       <= '0;
      r_head_tag    <= '0;
      r_outstanding <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        r_rob_score[i] <= '0;
        r_rob_row[i]   <= '0;
        r_rob_col[i]   <= '0;
        r_rob_core[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_res_hs[i]) begin
          r_rob_v[f_wrap(int'(r_core_tag[i]))]     <= 1'b1;
          r_rob_score[f_wrap(int'(r_core_tag[i]))] <= c_score[i*SCORE_W +: SCORE_W];
          r_rob_row[f_wrap(int'(r_core_tag[i]))]   <= c_row[i*ROWW +: ROWW];
          r_rob_col[f_wrap(int'(r_core_tag[i]))]   <= c_col[i*COLW +: COLW];
          r_rob_core[f_wrap(int'(r_core_tag[i]))]  <= CW'(i);
        end
      end
      // Placed after the writes so a bypassed head result never lingers.
      if (w_issue) begin
        r_rob_v[w_head] <= 1'b0;
        r_head_tag      <= r_head_tag + TAG_W'(1);
      end
      r_outstanding <= r_outstanding + BCW'(w_accept) - BCW'(w_issue);
    end
  end
`else
  logic [NUM_CORES-1:0] w_req;
  logic [CW-1:0]        r_res_rr;
  logic [CW-1:0]        w_cwin;
  logic                 w_any_req;

  assign w_s_ready = r_en & w_any_free;
  assign w_req     = c_res_valid & r_busy;

  always_comb begin
    w_any_req = 1'b0;
    w_cwin    = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (w_req[f_wrap(int'(r_res_rr) + k)]) begin
        w_any_req = 1'b1;
        w_cwin    = f_wrap(int'(r_res_rr) + k);
      end
    end
  end

  assign w_issue     = w_out_load & w_any_req;
  assign w_res_ready = w_issue ? (NUM_CORES'(1) << w_cwin) : '0;
  assign w_iss_score = c_score[int'(w_cwin)*SCORE_W +: SCORE_W];
  assign w_iss_row   = c_row[int'(w_cwin)*ROWW +: ROWW];
  assign w_iss_col   = c_col[int'(w_cwin)*COLW +: COLW];
  assign w_iss_tag   = r_core_tag[w_cwin];
  assign w_iss_core  = w_cwin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_rr <= '0;
    end else if (w_issue) begin
      r_res_rr <= f_wrap(int'(w_cwin) + 1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_m_score <= '0;
      r_m_row   <= '0;
      r_m_col   <= '0;
      r_m_tag   <= '0;
      r_m_core  <= '0;
    end else if (w_issue) begin
      r_m_valid <= 1'b1;
      r_m_score <= w_iss_score;
      r_m_row   <= w_iss_row;
      r_m_col   <= w_iss_col;
      r_m_tag   <= w_iss_tag;
      r_m_core  <= w_iss_core;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign s_ready     = w_s_ready;
  assign s_tag       = r_next_tag;
  assign c_valid     = r_c_valid;
  assign c_ref       = r_c_ref;
  assign c_read      = r_c_read;
  assign c_ref_len   = r_c_ref_len;
  assign c_read_len  = r_c_read_len;
  assign c_res_ready = w_res_ready;
  assign m_valid     = r_m_valid;
  assign m_score     = r_m_score;
  assign m_row       = r_m_row;
  assign m_col       = r_m_col;
  assign m_tag       = r_m_tag;
  assign m_core      = r_m_core;
  assign busy_cnt    = w_busy_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sw_job_dispatcher.sv
`default_nettype none
// Directed self-checking bench for sw_job_dispatcher (NUM_CORES=4, TAG_W=4).
module tb_sw_job_dispatcher;

  localparam int NC  = 4;
  localparam int SW  = 16;
  localparam int RW  = 7;
  localparam int CLW = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid;
  logic            s_ready;
  logic [255:0]    s_ref;
  logic [255:0]    s_read;
  logic [7:0]      s_ref_len;
  logic [7:0]      s_read_len;
  logic [3:0]      s_tag;
  logic [NC-1:0]   c_ready;
  logic [NC-1:0]   c_valid;
  logic [255:0]    c_ref;
  logic [255:0]    c_read;
  logic [7:0]      c_ref_len;
  logic [7:0]      c_read_len;
  logic [NC-1:0]   c_res_valid;
  logic [NC-1:0]   c_res_ready;
  logic [NC*SW-1:0]  c_score;
  logic [NC*RW-1:0]  c_row;
  logic [NC*CLW-1:0] c_col;
  logic            m_valid;
  logic            m_ready;
  logic [SW-1:0]   m_score;
  logic [RW-1:0]   m_row;
  logic [CLW-1:0]  m_col;
  logic [3:0]      m_tag;
  logic [1:0]      m_core;
  logic [2:0]      busy_cnt;

  int checks   = 0;
  int failures = 0;

  logic [255:0] ref_pat  = {8{32'hA5C31E7F}};
  logic [255:0] read_pat = {8{32'h3C96F00F}};

  sw_job_dispatcher #(.NUM_CORES(NC), .REF_MAX(128), .READ_MAX(128), .SCORE_W(SW), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_ref(s_ref), .s_read(s_read),
    .s_ref_len(s_ref_len), .s_read_len(s_read_len), .s_tag(s_tag),
    .c_ready(c_ready), .c_valid(c_valid), .c_ref(c_ref), .c_read(c_read),
    .c_ref_len(c_ref_len), .c_read_len(c_read_len),
    .c_res_valid(c_res_valid), .c_res_ready(c_res_ready),
    .c_score(c_score), .c_row(c_row), .c_col(c_col),
    .m_valid(m_valid), .m_ready(m_ready), .m_score(m_score), .m_row(m_row),
    .m_col(m_col), .m_tag(m_tag), .m_core(m_core), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input int core, input int score, input int row, input int col);
    c_res_valid[core]      = 1'b1;
    c_score[core*SW +: SW]   = SW'(score);
    c_row[core*RW +: RW]     = RW'(row);
    c_col[core*CLW +: CLW]   = CLW'(col);
  endtask

  task automatic drive_job();
    s_valid    = 1'b1;
    s_ref      = ref_pat;
    s_read     = read_pat;
    s_ref_len  = 8'd128;
    s_read_len = 8'd128;
  endtask

  task automatic do_reset();
    s_valid     = 1'b0;
    c_res_valid = '0;
    c_ready     = '1;
    m_ready     = 1'b1;
    rst         = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic send_job(output int tag);
    int t = 0;
    drive_job();
    #1;
    while (s_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    checks++; if (t >= 50) begin failures++; $display("FAIL send_job_timeout got s_ready=%b required=1", s_ready); end
    tag = int'(s_tag);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; s_valid = 1'b0; c_ready = '1; c_res_valid = '1; m_ready = 1'b1;
    c_score = '1; c_row = '1; c_col = '1;
    s_ref = '0; s_read = '0; s_ref_len = '0; s_read_len = '0;
    tick();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b required=0", s_ready); end
    checks++; if (c_valid !== 4'b0000) begin failures++; $display("FAIL rst_c_valid got=%b required=0000", c_valid); end
    checks++; if (c_res_ready !== 4'b0000) begin failures++; $display("FAIL rst_c_res_ready got=%b required=0000", c_res_ready); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b required=0", m_valid); end
    checks++; if ({m_score, m_row, m_col, m_tag, m_core} !== '0) begin failures++; $display("FAIL rst_m_data got=%h/%h/%h/%h/%h required=0", m_score, m_row, m_col, m_tag, m_core); end
    checks++; if (busy_cnt !== 3'd0) begin failures++; $display("FAIL rst_busy_cnt got=%0d required=0", busy_cnt); end
    checks++; if (s_tag !== 4'd0) begin failures++; $display("FAIL rst_s_tag got=%0d required=0", s_tag); end
    c_res_valid = '0;
    rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_release_s_ready got=%b required=0", s_ready); end
    tick();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL post_release_s_ready got=%b required=1", s_ready); end
  endtask

  task automatic test_single();
    drive_job();
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL single_s_ready got=%b required=1", s_ready); end
    checks++; if (s_tag !== 4'd0) begin failures++; $display("FAIL single_s_tag got=%0d required=0", s_tag); end
    tick();
    s_valid = 1'b0;
    checks++; if (c_valid !== 4'b0001) begin failures++; $display("FAIL single_c_valid got=%b required=0001", c_valid); end
    checks++; if (c_ref !== ref_pat || c_read !== read_pat) begin failures++; $display("FAIL single_c_seq got=%h required=%h", c_ref, ref_pat); end
    checks++; if (c_ref_len !== 8'd128 || c_read_len !== 8'd128) begin failures++; $display("FAIL single_c_len got=%0d/%0d required=128/128", c_ref_len, c_read_len); end
    checks++; if (busy_cnt !== 3'd1) begin failures++; $display("FAIL single_busy got=%0d required=1", busy_cnt); end
    set_res(0, 57, 101, 99);
    #1;
    checks++; if (c_res_ready !== 4'b0001) begin failures++; $display("FAIL single_c_res_ready got=%b required=0001", c_res_ready); end
    tick();
    c_res_valid = '0;
    checks++; if (c_valid !== 4'b0000) begin failures++; $display("FAIL single_c_valid_pulse got=%b required=0000", c_valid); end
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL single_m_valid got=%b required=1", m_valid); end
    checks++; if (m_score !== 16'd57 || m_row !== 7'd101 || m_col !== 7'd99) begin failures++; $display("FAIL single_m_data got=%0d/%0d/%0d required=57/101/99", m_score, m_row, m_col); end
    checks++; if (m_tag !== 4'd0 || m_core !== 2'd0) begin failures++; $display("FAIL single_m_tag_core got=%0d/%0d required=0/0", m_tag, m_core); end
    checks++; if (busy_cnt !== 3'd0) begin failures++; $display("FAIL single_busy_clear got=%0d required=0", busy_cnt); end
    tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_m_drain got=%b required=0", m_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    do_reset();
    drive_job();
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (s_ready !== 1'b1 || s_tag !== 4'(k)) begin failures++; $display("FAIL b2b_accept%0d got ready=%b tag=%0d required ready=1 tag=%0d", k, s_ready, s_tag, k); end
      tick();
      e = 4'(1 << k);
      checks++; if (c_valid !== e) begin failures++; $display("FAIL b2b_c_valid%0d got=%b required=%b", k, c_valid, e); end
      checks++; if (busy_cnt !== 3'(k + 1)) begin failures++; $display("FAIL b2b_busy%0d got=%0d required=%0d", k, busy_cnt, k + 1); end
    end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL b2b_fifth_blocked got=%b required=0", s_ready); end
    tick();
    checks++; if (c_valid !== 4'b0000 || busy_cnt !== 3'd4) begin failures++; $display("FAIL b2b_stall got c_valid=%b busy=%0d required 0000/4", c_valid, busy_cnt); end
    set_res(0, 7, 3, 3);
    #1;
    tick();
    c_res_valid = '0;
    checks++; if (busy_cnt !== 3'd3 || s_ready !== 1'b1) begin failures++; $display("FAIL b2b_free got busy=%0d ready=%b required 3/1", busy_cnt, s_ready); end
    checks++; if (s_tag !== 4'd4) begin failures++; $display("FAIL b2b_fifth_tag got=%0d required=4", s_tag); end
    checks++; if (m_valid !== 1'b1 || m_tag !== 4'd0) begin failures++; $display("FAIL b2b_result got valid=%b tag=%0d required 1/0", m_valid, m_tag); end
    tick();
    s_valid = 1'b0;
    checks++; if (c_valid !== 4'b0001) begin failures++; $display("FAIL b2b_fifth_core got=%b required=0001", c_valid); end
  endtask

  task automatic test_order();
    int order [4] = '{3, 1, 0, 2};
    int exp_tags [4];
    int got_tag [$];
    int got_core [$];
    int got_score [$];
    int tg;
`ifdef SW_REORDER_EN
    exp_tags = '{0, 1, 2, 3};
`else
    exp_tags = '{3, 1, 0, 2};
`endif
    do_reset();
    for (int k = 0; k < 4; k++) send_job(tg);
    for (int cyc = 0; cyc < 12; cyc++) begin
      c_res_valid = '0;
      if (cyc < 4) set_res(order[cyc], 100 + order[cyc], 0, 0);
      #1;
      if (m_valid && m_ready) begin
        got_tag.push_back(int'(m_tag));
        got_core.push_back(int'(m_core));
        got_score.push_back(int'(m_score));
      end
      tick();
    end
    c_res_valid = '0;
    checks++; if (got_tag.size() != 4) begin failures++; $display("FAIL order_count got=%0d required=4", got_tag.size()); end
    for (int i = 0; i < 4 && i < got_tag.size(); i++) begin
      checks++; if (got_tag[i] != exp_tags[i]) begin failures++; $display("FAIL order_tag%0d got=%0d required=%0d", i, got_tag[i], exp_tags[i]); end
      checks++; if (got_core[i] != exp_tags[i] || got_score[i] != 100 + exp_tags[i]) begin failures++; $display("FAIL order_data%0d got core=%0d score=%0d required core=%0d score=%0d", i, got_core[i], got_score[i], exp_tags[i], 100 + exp_tags[i]); end
    end
  endtask

  task automatic test_backpressure();
    int tg;
    logic hs;
    int got_tag [$];
    int got_score [$];
    do_reset();
    send_job(tg);
    send_job(tg);
    m_ready = 1'b0;
    set_res(0, 11, 1, 1);
    #1;
    tick();
    c_res_valid = '0;
    checks++; if (m_valid !== 1'b1 || m_tag !== 4'd0 || m_score !== 16'd11) begin failures++; $display("FAIL bp_first got valid=%b tag=%0d score=%0d required 1/0/11", m_valid, m_tag, m_score); end
    set_res(1, 22, 2, 2);
    #1;
`ifdef SW_REORDER_EN
    checks++; if (c_res_ready[1] !== 1'b1) begin failures++; $display("FAIL bp_rob_accept got=%b required=1", c_res_ready[1]); end
`else
    checks++; if (c_res_ready[1] !== 1'b0) begin failures++; $display("FAIL bp_hold_ready got=%b required=0", c_res_ready[1]); end
`endif
    for (int k = 0; k < 10; k++) begin
      hs = c_res_valid[1] & c_res_ready[1];
      tick();
      if (hs) c_res_valid[1] = 1'b0;
      checks++; if ({m_valid, m_score, m_tag} !== {1'b1, 16'd11, 4'd0}) begin failures++; $display("FAIL bp_stable%0d got valid=%b score=%0d tag=%0d required 1/11/0", k, m_valid, m_score, m_tag); end
`ifndef SW_REORDER_EN
      checks++; if (c_res_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready_low%0d got=%b required=0000", k, c_res_ready); end
`endif
      #1;
    end
    m_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (m_valid && m_ready) begin
        got_tag.push_back(int'(m_tag));
        got_score.push_back(int'(m_score));
      end
      hs = c_res_valid[1] & c_res_ready[1];
      tick();
      if (hs) c_res_valid[1] = 1'b0;
    end
    c_res_valid = '0;
    checks++; if (got_tag.size() != 2) begin failures++; $display("FAIL bp_count got=%0d required=2", got_tag.size()); end
    for (int i = 0; i < 2 && i < got_tag.size(); i++) begin
      checks++; if (got_tag[i] != i || got_score[i] != 11 * (i + 1)) begin failures++; $display("FAIL bp_result%0d got tag=%0d score=%0d required tag=%0d score=%0d", i, got_tag[i], got_score[i], i, 11 * (i + 1)); end
    end
  endtask

  task automatic test_wrap();
    int tg;
    logic [3:0] e;
    do_reset();
    for (int j = 0; j < 20; j++) begin
      send_job(tg);
      checks++; if (tg != j % 16) begin failures++; $display("FAIL wrap_s_tag%0d got=%0d required=%0d", j, tg, j % 16); end
      e = 4'(1 << (j % 4));
      checks++; if (c_valid !== e) begin failures++; $display("FAIL wrap_c_valid%0d got=%b required=%b", j, c_valid, e); end
      set_res(j % 4, j, 0, 0);
      #1;
      tick();
      c_res_valid = '0;
      checks++; if (m_valid !== 1'b1 || m_tag !== 4'(j % 16) || m_score !== 16'(j)) begin failures++; $display("FAIL wrap_result%0d got valid=%b tag=%0d score=%0d required 1/%0d/%0d", j, m_valid, m_tag, m_score, j % 16, j); end
      checks++; if (m_core !== 2'(j % 4)) begin failures++; $display("FAIL wrap_core%0d got=%0d required=%0d", j, m_core, j % 4); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int tg;
    do_reset();
    for (int k = 0; k < 3; k++) send_job(tg);
    m_ready = 1'b0;
    set_res(0, 5, 1, 1);
    #1;
    tick();
    c_res_valid = '0;
    checks++; if (m_valid !== 1'b1 || busy_cnt !== 3'd2) begin failures++; $display("FAIL mid_pre got valid=%b busy=%0d required 1/2", m_valid, busy_cnt); end
    #3;
    rst = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || m_score !== 16'd0 || m_tag !== 4'd0) begin failures++; $display("FAIL mid_async_m got valid=%b score=%0d tag=%0d required 0/0/0", m_valid, m_score, m_tag); end
    checks++; if (busy_cnt !== 3'd0 || c_valid !== 4'b0000 || s_ready !== 1'b0) begin failures++; $display("FAIL mid_async_ctl got busy=%0d c_valid=%b s_ready=%b required 0/0000/0", busy_cnt, c_valid, s_ready); end
    set_res(1, 9, 0, 0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (c_res_ready !== 4'b0000) begin failures++; $display("FAIL mid_stale_result got=%b required=0000", c_res_ready); end
    tick();
    c_res_valid = '0;
    drive_job();
    #1;
    checks++; if (s_ready !== 1'b1 || s_tag !== 4'd0) begin failures++; $display("FAIL mid_restart got ready=%b tag=%0d required 1/0", s_ready, s_tag); end
    tick();
    s_valid = 1'b0;
    checks++; if (c_valid !== 4'b0001) begin failures++; $display("FAIL mid_restart_core got=%b required=0001", c_valid); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_order();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
